csa_accum_sequencer: RTL and testbench
======================================

# csa_accum_sequencer

Sequential carry-save accumulator controller. It time-shares one W-bit row of 3:2 compressors (full-adder cells: sum = XOR3, carry = MAJ3) to reduce an arbitrary-length stream of partial products into a single result. It sits between the partial-product generator and the Posit fraction/normalisation stage of the FMAU. Use it where area matters more than throughput; a full Wallace tree is too large there.

## Interface
- W, default 32: operand, result and internal sum/carry register width.
- CNTW, default 8: width of the operand counter.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  W  partial product, already aligned to result weight.
- in_last  in  1  marks the final operand of the current job.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  sum of all job operands, modulo 2^W.
- out_count  out  CNTW  number of operands in the job, saturating at 2^CNTW-1.
- out_sat  out  1  operand count saturated during the job.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- State machine with four states: IDLE, ACCUM, RESOLVE, OUT.
- A beat is accepted on a rising edge when in_valid && in_ready.
- in_ready = (state==IDLE) || (state==ACCUM). It is low in RESOLVE and OUT.
- Internal registers:
  - S[W]: partial sum.
  - C[W]: carry vector, stored already shifted to result weight, so C[0] is always 0.
  - cnt[CNTW]: operand counter.
  - sat: counter-saturation flag.
- IDLE, on an accepted beat:
  - S<=in_data, C<=0, cnt<=1, sat<=0.
  - Next state is RESOLVE if in_last, else ACCUM.
- ACCUM, on an accepted beat:
  - For each bit i: s_i = S[i]^C[i]^in_data[i] and m_i = MAJ(S[i],C[i],in_data[i]).
  - S<=s, C<={m[W-2:0],1'b0}; m[W-1] is discarded (modulo 2^W).
  - cnt<=cnt+1, saturating at all-ones; sat<=1 if cnt was already all-ones.
  - Next state is RESOLVE if in_last, else stay in ACCUM.
  - With no accepted beat, all registers hold.
- RESOLVE, unconditional, one cycle:
  - out_data<=(S+C) mod 2^W, out_count<=cnt, out_sat<=sat, out_valid<=1.
  - Next state is OUT.
- OUT:
  - Hold out_data, out_count, out_sat and out_valid stable while out_ready is low.
  - On out_valid && out_ready: out_valid<=0, next state IDLE.
  - out_data, out_count and out_sat keep their last values after the handshake.
- Job length: there is no minimum beyond one operand and no maximum. The arithmetic stays exact modulo 2^W at any length; only out_count saturates.
- in_data and in_last are ignored on cycles when in_ready is low.
- Reset, asserted at any time including mid-job:
  - Immediately forces state IDLE and clears S, C, cnt, sat, out_data, out_count, out_sat and out_valid to 0.
  - The partial job is discarded. Nothing is emitted for it.
- Reset values of outputs: in_ready=1 (IDLE), out_valid=0, out_data=0, out_count=0, out_sat=0, busy=0.

## Timing
- Throughput in ACCUM: one operand per cycle. There are no bubbles between beats.
- Latency: if the in_last beat is accepted at edge t, the RESOLVE edge is t+1 and out_valid is high after edge t+1.
- If out_ready is already high, the result handshake completes at edge t+2. in_ready rises after edge t+2, so the next job's first beat is accepted no earlier than edge t+3.
- Minimum job period is (N operands) + 2 cycles.
- No combinational path from in_valid or out_ready to any output; in_ready and busy depend on state only.
- Critical path is the W-bit carry-propagate add in RESOLVE. The ACCUM path is one full-adder deep regardless of W.

## Test plan
- W=32: beats 5, 7, 9(last) with out_ready=1 -> out_data=21, out_count=3, out_sat=0. out_valid is high exactly one cycle, two edges after the last beat.
- Single beat 0xDEADBEEF with in_last=1 -> out_data=0xDEADBEEF, out_count=1. in_ready is low for the RESOLVE and OUT cycles only.
- W=8, wrap-around: 200, 100, 0xFF(last) -> out_data=(555 mod 256)=43, out_count=3. Check carry-heavy operands 0xFF x4 -> out_data=0xFC.
- Backpressure: after job 1+2+3, hold out_ready=0 for 10 cycles -> out_valid, out_data=6 and out_count=3 remain stable and in_ready=0. Drive in_valid during the stall and check those beats are ignored. out_ready=1 returns the block to IDLE the next edge.
- CNTW=8, W=32: 300 beats of value 1 with in_valid gaps randomly inserted -> out_data=300, out_count=255, out_sat=1.
- Drop rst_n asynchronously (between clock edges) after 3 of 5 beats -> state IDLE, all outputs zero, no out_valid. A new job 4, 4(last) after release -> out_data=8, out_count=2.

Source files
------------

// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer
// Sequential carry-save accumulator. It folds a stream of aligned partial
// products into redundant sum/carry form using a single row of full-adder
// cells. One carry-propagate add at the end of the job resolves the result.
//
// Handshake rules, shared by both ports: a transfer happens on a rising clock
// edge where valid && ready. The producer holds valid, and the data that goes
// with it, until the transfer. ready never depends combinationally on valid.
// in_ready and busy decode the registered state only. Every other output is
// registered.

module csa_accum_sequencer #(
   parameter int W    = 32,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_data,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_data,
   output logic [CNTW-1:0] out_count,
   output logic            out_sat,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      OUT     = 2'd3
   } state_t;

   state_t          state;
   logic [W-1:0]    s_q;       // redundant partial sum
   logic [W-1:0]    c_q;       // carry vector, already at result weight (bit 0 always 0)
   logic [CNTW-1:0] cnt_q;     // operands seen this job, saturating
   logic            sat_q;     // counter hit all-ones and another beat arrived

   logic            beat;
   logic [W-1:0]    csa_sum;
   logic [W-1:0]    csa_maj;
   logic            cnt_full;

   // Operands are only taken while gathering a job.
   assign in_ready = (state == IDLE) || (state == ACCUM);
   assign busy     = (state != IDLE);
   assign beat     = in_valid && in_ready;
   assign cnt_full = &cnt_q;

   // One level of 3:2 compressors. The depth is one full adder at any W.
   assign csa_sum = s_q ^ c_q ^ in_data;
   assign csa_maj = (s_q & c_q) | (s_q & in_data) | (c_q & in_data);

   // Controller and datapath registers, all in one process so that each state
   // and its register updates can be read together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         s_q       <= '0;
         c_q       <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // The first operand loads the sum register directly. No add is needed.
               if (beat) begin
                  s_q   <= in_data;
                  c_q   <= '0;
                  cnt_q <= CNTW'(1);
                  sat_q <= 1'b0;
                  state <= in_last ? RESOLVE : ACCUM;
               end
            end
            ACCUM: begin
               if (beat) begin
                  s_q <= csa_sum;
                  // The carry out of the top bit is dropped, so the result is modulo 2^W.
                  c_q <= {csa_maj[W-2:0], 1'b0};
                  if (cnt_full) begin
                     sat_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNTW'(1);
                  end
                  state <= in_last ? RESOLVE : ACCUM;
               end
            end
            RESOLVE: begin
               // The only carry-propagate add in the block.
               out_data  <= s_q + c_q;
               out_count <= cnt_q;
               out_sat   <= sat_q;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               // The result holds until it is accepted. Data fields keep their values afterwards.
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Directed bench for csa_accum_sequencer. Instance a uses W=32 and instance b
// uses W=8. Both instances share one clock and one reset.

module tb_csa_accum_sequencer;

   localparam int W  = 32;
   localparam int WB = 8;
   localparam int CW = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- DUT a (W=32) ----------------
   logic          a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_sat, a_busy;
   logic [W-1:0]  a_in_data, a_out_data;
   logic [CW-1:0] a_out_count;

   csa_accum_sequencer #(.W(W), .CNTW(CW)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_count(a_out_count), .out_sat(a_out_sat), .busy(a_busy)
   );

   // ---------------- DUT b (W=8) ----------------
   logic          b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_sat, b_busy;
   logic [WB-1:0] b_in_data, b_out_data;
   logic [CW-1:0] b_out_count;

   csa_accum_sequencer #(.W(WB), .CNTW(CW)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_count(b_out_count), .out_sat(b_out_sat), .busy(b_busy)
   );

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      int             n;
      logic [3:0][31:0] ops;
      logic [31:0]    exp_data;
      logic [7:0]     exp_count;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Runs one job on instance a with out_ready high. It checks the exact latency.
   task automatic run_job_a(input vec_t v, input string tag);
      logic [W-1:0] exp_d;
      exp_q.push_back(v.exp_data);
      for (int i = 0; i < v.n; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = v.ops[i];
         a_in_last  = (i == v.n - 1);
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      // The last beat was taken at edge t. The block is now in RESOLVE.
      check({tag, " resolve in_ready"}, a_in_ready, 0);
      check({tag, " resolve out_valid"}, a_out_valid, 0);
      check({tag, " resolve busy"}, a_busy, 1);
      @(posedge clk); #1;
      // After edge t+1 the result is presented.
      exp_d = exp_q.pop_front();
      check({tag, " out_valid"}, a_out_valid, 1);
      check({tag, " out in_ready"}, a_in_ready, 0);
      check({tag, " out_data"}, a_out_data, exp_d);
      check({tag, " out_count"}, a_out_count, v.exp_count);
      check({tag, " out_sat"}, a_out_sat, 0);
      @(posedge clk); #1;
      // The handshake completes at edge t+2. The block is back in IDLE.
      check({tag, " post out_valid"}, a_out_valid, 0);
      check({tag, " post in_ready"}, a_in_ready, 1);
      check({tag, " post busy"}, a_busy, 0);
      check({tag, " post data held"}, a_out_data, exp_d);
   endtask

   // Runs one job on instance b and checks the result.
   task automatic run_job_b(input int n, input logic [3:0][7:0] ops, input logic [7:0] exp_d,
                            input logic [7:0] exp_c, input string tag);
      for (int i = 0; i < n; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = ops[i];
         b_in_last  = (i == n - 1);
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      @(posedge clk); #1;
      check({tag, " out_valid"}, b_out_valid, 1);
      check({tag, " out_data"}, b_out_data, exp_d);
      check({tag, " out_count"}, b_out_count, exp_c);
      @(posedge clk); #1;
      check({tag, " post busy"}, b_busy, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vec_t v;
      int   waited;

      vecs[0] = '{3, {32'd0, 32'd9, 32'd7, 32'd5}, 32'd21, 8'd3};
      vecs[1] = '{1, {32'd0, 32'd0, 32'd0, 32'hDEADBEEF}, 32'hDEADBEEF, 8'd1};
      vecs[2] = '{4, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 32'hFFFFFFFC, 8'd4};
      vecs[3] = '{4, {32'h80000000, 32'h80000000, 32'h12345678, 32'd1}, 32'h12345679, 8'd4};

      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
      #12;
      check("reset in_ready", a_in_ready, 1);
      check("reset out_valid", a_out_valid, 0);
      check("reset out_data", a_out_data, 0);
      check("reset out_count", a_out_count, 0);
      check("reset out_sat", a_out_sat, 0);
      check("reset busy", a_busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven jobs.
      for (int i = 0; i < 4; i++) begin
         run_job_a(vecs[i], $sformatf("vec%0d", i));
      end

      // W=8 wrap-around and carry-heavy operands.
      run_job_b(3, {8'd0, 8'hFF, 8'd100, 8'd200}, 8'd43, 8'd3, "w8 wrap");
      run_job_b(4, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFC, 8'd4, "w8 ff4");

      // Backpressure. Beats driven during the stall must be ignored.
      a_out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         a_in_valid = 1'b1; a_in_data = W'(i); a_in_last = (i == 3);
         @(posedge clk); #1;
      end
      a_in_data = 32'd99; a_in_last = 1'b1;   // in_valid stays high as junk
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("stall%0d out_valid", k), a_out_valid, 1);
         check($sformatf("stall%0d out_data", k), a_out_data, 6);
         check($sformatf("stall%0d out_count", k), a_out_count, 3);
         check($sformatf("stall%0d in_ready", k), a_in_ready, 0);
         @(posedge clk); #1;
      end
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_in_last = 1'b0;
      check("stall release out_valid", a_out_valid, 0);
      check("stall release in_ready", a_in_ready, 1);
      @(posedge clk); #1;
      check("stall junk ignored busy", a_busy, 0);

      // Counter saturation, with random gaps between beats.
      for (int i = 0; i < 300; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            a_in_valid = 1'b0;
            @(posedge clk); #1;
         end
         a_in_valid = 1'b1; a_in_data = 32'd1; a_in_last = (i == 299);
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0; a_in_last = 1'b0;
      waited = 0;
      while (!a_out_valid && waited < 5) begin
         @(posedge clk); #1;
         waited++;
      end
      check("sat out_valid seen", a_out_valid, 1);
      check("sat out_data", a_out_data, 300);
      check("sat out_count", a_out_count, 255);
      check("sat out_sat", a_out_sat, 1);
      @(posedge clk); #1;
      check("sat post busy", a_busy, 0);

      // Asynchronous reset in the middle of a job.
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1; a_in_data = W'(10 * (i + 1)); a_in_last = 1'b0;
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      check("midjob busy", a_busy, 1);
      #3 rst_n = 1'b0;
      #1;
      check("async rst in_ready", a_in_ready, 1);
      check("async rst busy", a_busy, 0);
      check("async rst out_valid", a_out_valid, 0);
      check("async rst out_data", a_out_data, 0);
      check("async rst out_count", a_out_count, 0);
      check("async rst out_sat", a_out_sat, 0);
      check("async rst b out_data", b_out_data, 0);
      @(posedge clk); #1;
      check("in rst out_valid", a_out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("after rst out_valid", a_out_valid, 0);
      v = '{2, {32'd0, 32'd0, 32'd4, 32'd4}, 32'd8, 8'd2};
      run_job_a(v, "post-reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time limit, so the run can never hang.
   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
